// File: rtl/i2c_slave_oe_if.sv
// Pad (split in/oe/out) and byte-stream signals of the I2C target.
// The slave modport is the target's view; master is the bus/host side.
interface i2c_slave_oe_if #(
    parameter int DATA_DEPTH = 8
) ();
    logic                  i_sda_in;
    logic                  i_scl_in;
    logic                  o_sda_oe;
    logic                  o_scl_oe;
    logic                  o_sda_out;
    logic                  o_scl_out;
    logic [DATA_DEPTH-1:0] o_data_bits;
    logic                  o_data_valid;
    logic                  i_data_ready;
    logic [DATA_DEPTH-1:0] i_data_bits;
    logic                  i_data_valid;
    logic                  o_data_ready;
    logic                  o_busy;
    logic                  o_nak;

    modport slave (
        input  i_sda_in, i_scl_in, i_data_ready, i_data_bits, i_data_valid,
        output o_sda_oe, o_scl_oe, o_sda_out, o_scl_out, o_data_bits, o_data_valid,
               o_data_ready, o_busy, o_nak
    );

    modport master (
        output i_sda_in, i_scl_in, i_data_ready, i_data_bits, i_data_valid,
        input  o_sda_oe, o_scl_oe, o_sda_out, o_scl_out, o_data_bits, o_data_valid,
               o_data_ready, o_busy, o_nak
    );
endinterface

// File: rtl/i2c_slave_oe.sv
// Open-drain I2C target: oversampled START/STOP detection, 7-bit address match, ready/valid byte streams.
// Define I2C_SLAVE_CLOCK_STRETCH_EN to stretch SCL instead of NAKing full RX / sending 0xFF on empty TX.
module i2c_slave_oe #(
    parameter int         DATA_DEPTH  = 8,
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input logic           i_clk,
    input logic           i_rst,
    i2c_slave_oe_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
    logic                   sda_prev_q, scl_prev_q;
    logic [3:0]             cnt_q;
    logic [DATA_DEPTH-1:0]  rx_sh_q, tx_sh_q, data_bits_q;
    logic                   rw_q, sda_oe_q, data_valid_q, data_ready_q, busy_q, nak_q;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    logic                   stretch_q, scl_oe_q;
`endif

    logic sda_s, scl_s, scl_rise, scl_fall, start_c, stop_c, byte_done, out_free, fetch_c;

    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_c   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_done = scl_fall && (cnt_q == 4'(DATA_DEPTH));
    // A handshake in the same cycle frees the output register for the new byte.
    assign out_free  = !data_valid_q || bus.i_data_ready;
    assign fetch_c   = scl_fall && ((state_q == ADDR_ACK && rw_q) || state_q == TX_ACK);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            sda_sync_q   <= '1;
            scl_sync_q   <= '1;
            sda_prev_q   <= 1'b1;
            scl_prev_q   <= 1'b1;
            cnt_q        <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            data_bits_q  <= '0;
            rw_q         <= 1'b0;
            sda_oe_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            nak_q        <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            stretch_q    <= 1'b0;
            scl_oe_q     <= 1'b0;
`endif
        end else begin
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], bus.i_sda_in};
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], bus.i_scl_in};
            sda_prev_q   <= sda_s;
            scl_prev_q   <= scl_s;
            data_ready_q <= 1'b0;
            nak_q        <= 1'b0;
            if (data_valid_q && bus.i_data_ready) data_valid_q <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            // SCL is let go one clock after SDA settles so the master sees stable data.
            if (scl_oe_q && !stretch_q) scl_oe_q <= 1'b0;
`endif
            if (scl_rise) begin
                rx_sh_q <= {rx_sh_q[DATA_DEPTH-2:0], sda_s};
                cnt_q   <= cnt_q + 4'd1;
            end

            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (byte_done) begin
                        if (rx_sh_q[DATA_DEPTH-1 -: 7] == SLAVE_ADDR && SLAVE_ADDR != 7'd0) begin
                            state_q  <= ADDR_ACK;
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            rw_q     <= rx_sh_q[0];
                        end else begin
                            state_q  <= WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= RX;
                        cnt_q    <= '0;
                    end
                end
                RX: begin
                    if (byte_done) begin
                        state_q <= RX_ACK;
                        if (out_free) begin
                            data_bits_q  <= rx_sh_q;
                            data_valid_q <= 1'b1;
                            sda_oe_q     <= 1'b1;
                        end
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                        else begin
                            stretch_q <= 1'b1;
                            scl_oe_q  <= 1'b1;
                        end
`endif
                    end
                end
                RX_ACK: begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                    if (stretch_q) begin
                        if (out_free) begin
                            data_bits_q  <= rx_sh_q;
                            data_valid_q <= 1'b1;
                            sda_oe_q     <= 1'b1;
                            stretch_q    <= 1'b0;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= RX;
                        cnt_q    <= '0;
                    end
                end
                TX: begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                    if (stretch_q) begin
                        if (bus.i_data_valid) begin
                            tx_sh_q      <= bus.i_data_bits;
                            data_ready_q <= 1'b1;
                            sda_oe_q     <= ~bus.i_data_bits[DATA_DEPTH-1];
                            stretch_q    <= 1'b0;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        if (cnt_q == 4'(DATA_DEPTH)) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= TX_ACK;
                        end else begin
                            sda_oe_q <= ~tx_sh_q[DATA_DEPTH-2];
                            tx_sh_q  <= tx_sh_q << 1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        nak_q   <= 1'b1;
                        state_q <= WAIT_STOP;
                    end
                end
                WAIT_STOP: ;
                default: state_q <= IDLE;
            endcase

            // Fetch at the falling edge closing an ACK clock; MSB goes out right away.
            if (fetch_c) begin
                state_q <= TX;
                cnt_q   <= '0;
                if (bus.i_data_valid) begin
                    tx_sh_q      <= bus.i_data_bits;
                    data_ready_q <= 1'b1;
                    sda_oe_q     <= ~bus.i_data_bits[DATA_DEPTH-1];
                end else begin
                    sda_oe_q <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
                    stretch_q <= 1'b1;
                    scl_oe_q  <= 1'b1;
`else
                    tx_sh_q   <= '1;
`endif
                end
            end

            if (start_c) begin
                state_q  <= ADDR;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_c) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end
        end
    end

    assign bus.o_sda_out    = 1'b0;
    assign bus.o_scl_out    = 1'b0;
    assign bus.o_sda_oe     = sda_oe_q;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    assign bus.o_scl_oe     = scl_oe_q;
`else
    assign bus.o_scl_oe     = 1'b0;
`endif
    assign bus.o_data_bits  = data_bits_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_data_ready = data_ready_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_nak        = nak_q;
endmodule

// File: tb/tb_i2c_slave_oe.sv
// Directed bench for i2c_slave_oe: open-drain bus master model, byte sink/source models,
// a table of write transactions plus hand sequences for read, reset, repeated START and stretching.
module tb_i2c_slave_oe;
    localparam int Q = 10;  // quarter SCL period in system clocks

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       m_sda_low = 1'b0, m_scl_low = 1'b0;
    logic       sink_ready = 1'b0, src_en = 1'b0;
    logic [7:0] src_mem [0:15];
    logic [7:0] cap_mem [0:63];
    int         src_avail = 0;
    int         pop_total = 0, cap_total = 0, rdy_total = 0, nak_total = 0;
    int         oe_cycles = 0, stretch_cycles = 0, viol_total = 0;
    logic       sda_oe_prev = 1'b0;
    int         checks = 0, errors = 0;
    wire        sda_line, scl_line;

    i2c_slave_oe_if #(.DATA_DEPTH(8)) bus ();

    i2c_slave_oe #(.DATA_DEPTH(8), .SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign sda_line         = ~(m_sda_low | bus.o_sda_oe);
    assign scl_line         = ~(m_scl_low | bus.o_scl_oe);
    assign bus.i_sda_in     = sda_line;
    assign bus.i_scl_in     = scl_line;
    assign bus.i_data_ready = sink_ready;
    assign bus.i_data_valid = src_en && (pop_total < src_avail);
    assign bus.i_data_bits  = src_mem[pop_total[3:0]];

    always @(posedge clk) begin
        if (bus.o_data_valid && sink_ready) begin
            cap_mem[cap_total[5:0]] <= bus.o_data_bits;
            cap_total <= cap_total + 1;
        end
        if (bus.o_data_ready) rdy_total <= rdy_total + 1;
        if (bus.o_data_ready && bus.i_data_valid) pop_total <= pop_total + 1;
        if (bus.o_nak) nak_total <= nak_total + 1;
        if (bus.o_sda_oe) oe_cycles <= oe_cycles + 1;
        if (bus.o_scl_oe) stretch_cycles <= stretch_cycles + 1;
        if (rst && bus.o_sda_oe !== sda_oe_prev && scl_line) viol_total <= viol_total + 1;
        sda_oe_prev <= bus.o_sda_oe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_release();
        int n;
        n = 0;
        m_scl_low = 1'b0;
        while (scl_line !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (scl_line !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_release timeout scl=%b required=1", scl_line);
        end
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_sda_low = ~b;
        tick(Q);
        scl_release();
        tick(Q);
        s = sda_line;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        tick(Q);
        scl_release();
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(Q);
        scl_release();
        tick(Q);
        m_sda_low = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        logic [7:0] t;
        t = '0;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            t[i] = s;
        end
        i2c_bit(~mack, s);
        d = t;
    endtask

    typedef struct {
        logic [7:0] addr, d0, d1;
        logic       ready;
        int         rdy_at;
        logic       ack_a, ack0, ack1;
        int         ncap;
        logic [7:0] c0, c1;
    } wvec_t;

    wvec_t tv [5];

    initial begin
        logic       ka, k0, k1, busy_mid, busy_end;
        logic [7:0] r0, r1, exp_rd;
        int         c0, o0, p0, n0, s0, exp_rdy, exp_st;

        tv[0] = '{8'h84, 8'h5A, 8'hC3, 1'b1, 0, 1'b1, 1'b1, 1'b1, 2, 8'h5A, 8'hC3};
        tv[1] = '{8'h86, 8'h12, 8'h34, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00};
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
        tv[2] = '{8'h84, 8'h11, 8'h22, 1'b0, 1300, 1'b1, 1'b1, 1'b1, 2, 8'h11, 8'h22};
`else
        tv[2] = '{8'h84, 8'h11, 8'h22, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, 8'h11, 8'h00};
`endif
        tv[3] = '{8'h00, 8'h55, 8'hAA, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00};
        tv[4] = '{8'h84, 8'hFF, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b1, 2, 8'hFF, 8'h00};

        tick(3);
        chk("reset_ctrl_outs", {bus.o_sda_oe, bus.o_scl_oe, bus.o_data_valid, bus.o_data_ready,
                                bus.o_busy, bus.o_nak, bus.o_sda_out, bus.o_scl_out}, 0);
        chk("reset_data_bits", bus.o_data_bits, 0);
        rst = 1'b1;
        tick(5);

        for (int i = 0; i < 5; i++) begin
            c0 = cap_total;
            o0 = oe_cycles;
            sink_ready = tv[i].ready;
            fork
                begin
                    i2c_start();
                    write_byte(tv[i].addr, ka);
                    busy_mid = bus.o_busy;
                    write_byte(tv[i].d0, k0);
                    write_byte(tv[i].d1, k1);
                    i2c_stop();
                end
                begin
                    if (tv[i].rdy_at != 0) begin
                        tick(tv[i].rdy_at);
                        sink_ready = 1'b1;
                    end
                end
            join
            tick(4);
            busy_end = bus.o_busy;
            sink_ready = 1'b1;
            tick(6);
            chk($sformatf("v%0d_addr_ack", i), ka, tv[i].ack_a);
            chk($sformatf("v%0d_busy_after_addr", i), busy_mid, tv[i].ack_a);
            chk($sformatf("v%0d_d0_ack", i), k0, tv[i].ack0);
            chk($sformatf("v%0d_d1_ack", i), k1, tv[i].ack1);
            chk($sformatf("v%0d_sda_driven", i), oe_cycles != o0, tv[i].ack_a);
            chk($sformatf("v%0d_busy_after_stop", i), busy_end, 1'b0);
            chk($sformatf("v%0d_valid_count", i), cap_total - c0, tv[i].ncap);
            if (tv[i].ncap > 0) chk($sformatf("v%0d_byte0", i), cap_mem[c0], tv[i].c0);
            if (tv[i].ncap > 1) chk($sformatf("v%0d_byte1", i), cap_mem[c0 + 1], tv[i].c1);
        end

        // Master read of two bytes: ACK then NAK.
        src_mem[pop_total[3:0]] = 8'h3C;
        src_mem[4'(pop_total + 1)] = 8'hA7;
        src_avail = pop_total + 2;
        src_en = 1'b1;
        p0 = rdy_total;
        n0 = nak_total;
        i2c_start();
        write_byte(8'h85, ka);
        read_byte(1'b1, r0);
        read_byte(1'b0, r1);
        i2c_stop();
        tick(4);
        src_en = 1'b0;
        chk("rd_addr_ack", ka, 1'b1);
        chk("rd_byte0", r0, 8'h3C);
        chk("rd_byte1", r1, 8'hA7);
        chk("rd_ready_pulses", rdy_total - p0, 2);
        chk("rd_nak_pulses", nak_total - n0, 1);
        chk("rd_busy_after_stop", bus.o_busy, 1'b0);

        // Read with the source empty at fetch; it becomes valid with 0x99 later.
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
        exp_rd = 8'h99; exp_rdy = 1; exp_st = 1;
`else
        exp_rd = 8'hFF; exp_rdy = 0; exp_st = 0;
`endif
        src_mem[pop_total[3:0]] = 8'h99;
        src_avail = pop_total + 1;
        p0 = rdy_total;
        n0 = nak_total;
        s0 = stretch_cycles;
        i2c_start();
        write_byte(8'h85, ka);
        fork
            read_byte(1'b0, r0);
            begin
                tick(200);
                src_en = 1'b1;
            end
        join
        i2c_stop();
        tick(4);
        src_en = 1'b0;
        chk("empty_addr_ack", ka, 1'b1);
        chk("empty_rd_byte", r0, exp_rd);
        chk("empty_ready_pulses", rdy_total - p0, exp_rdy);
        chk("empty_stretched", stretch_cycles != s0, exp_st);
        chk("empty_nak_pulses", nak_total - n0, 1);

        // Reset during the address ACK clock, then a normal write.
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            logic s;
            a = 8'h84;
            i2c_bit(a[i], s);
        end
        chk("rst_mid_sda_oe_before", bus.o_sda_oe, 1'b1);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_sda_oe_after", bus.o_sda_oe, 1'b0);
        chk("rst_mid_busy_after", bus.o_busy, 1'b0);
        rst = 1'b1;
        tick(2);
        begin
            logic s;
            i2c_bit(1'b1, s);
        end
        i2c_stop();
        tick(4);
        c0 = cap_total;
        i2c_start();
        write_byte(8'h84, ka);
        write_byte(8'h3E, k0);
        i2c_stop();
        tick(6);
        chk("post_rst_addr_ack", ka, 1'b1);
        chk("post_rst_data_ack", k0, 1'b1);
        chk("post_rst_valid_count", cap_total - c0, 1);
        chk("post_rst_byte", cap_mem[c0], 8'h3E);

        // Repeated START lifts the block out of the no-match wait.
        c0 = cap_total;
        i2c_start();
        write_byte(8'h86, ka);
        i2c_start();
        write_byte(8'h84, k0);
        write_byte(8'h77, k1);
        i2c_stop();
        tick(6);
        chk("rs_wrong_addr_ack", ka, 1'b0);
        chk("rs_addr_ack", k0, 1'b1);
        chk("rs_data_ack", k1, 1'b1);
        chk("rs_byte", cap_mem[c0], 8'h77);

        chk("sda_change_while_scl_high", viol_total, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_oe.md
Name: i2c_slave_oe

Overview:
- I2C target (responder) that pairs with the team's i2c_master_oe on the same bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches one 7-bit address. Master writes become a ready/valid byte stream out; a ready/valid byte stream in supplies master reads.
- Pads use split in/oe/out lines, the same way the master uses them. The bus is open-drain only: outputs are always 0, and oe=1 pulls the line low.

Parameters:
- DATA_DEPTH, 8: byte width. Only 8 is legal.
- SLAVE_ADDR, 7'h42: 7-bit address this block responds to.
- SYNC_STAGES, 2: flip-flop synchronizer depth on i_sda_in and i_scl_in. Must be 2 or more.

Ports:
- i_clk  in  1  system clock. Must be at least 16x SCL.
- i_rst  in  1  synchronous reset, active-low (0 = reset).
- i_sda_in  in  1  SDA pad input.
- i_scl_in  in  1  SCL pad input.
- o_sda_oe  out  1  1 = pull SDA low.
- o_scl_oe  out  1  1 = pull SCL low (clock stretch).
- o_sda_out  out  1  tied to 0.
- o_scl_out  out  1  tied to 0.
- o_data_bits  out  DATA_DEPTH  byte written by the master.
- o_data_valid  out  1  o_data_bits is valid.
- i_data_ready  in  1  consumer accepts o_data_bits.
- i_data_bits  in  DATA_DEPTH  byte to return on a master read.
- i_data_valid  in  1  i_data_bits is valid.
- o_data_ready  out  1  block takes i_data_bits this cycle.
- o_busy  out  1  1 while addressed (address ACK until STOP or START).
- o_nak  out  1  one-cycle pulse when the master NAKs a read byte.

Behaviour:
- Reset (i_rst=0 at a clock edge): state IDLE.
  - Outputs: o_sda_oe=0, o_scl_oe=0, o_data_valid=0, o_data_bits=0, o_data_ready=0, o_busy=0, o_nak=0.
  - Synchronizers are loaded with 1.
  - A reset in the middle of a transfer releases both lines on the next clock.
- Edge detection uses the synchronized signals, one clock of history each:
  - scl_rise, scl_fall.
  - START = SDA falls while SCL=1. STOP = SDA rises while SCL=1.
  - START and STOP override any state. START goes to ADDR with the bit count at 0. STOP goes to IDLE.
- Sampling and driving:
  - Data is sampled on scl_rise, MSB first.
  - o_sda_oe changes only on the clock after scl_fall, never while SCL=1.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7-bit address plus R/W).
    - Address match: go to ADDR_ACK.
    - No match: go to WAIT_STOP with SDA released.
  - ADDR_ACK: drive SDA low for the 9th clock and set o_busy=1. Then go to RX if R/W=0, or TX if R/W=1.
  - RX: shift 8 bits, then go to RX_ACK.
    - If the output register is empty, load the byte, set o_data_valid=1 and ACK.
    - If the output register is full, NAK: SDA released and the byte is dropped.
    - After the 9th clock, return to RX.
  - TX: a byte is fetched at the scl_fall that ends the ACK clock.
    - If i_data_valid=1, o_data_ready pulses for one clock and the byte is latched.
    - If i_data_valid=0, 8'hFF is sent.
    - Each 0 bit drives SDA low; each 1 bit releases it. After 8 bits, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - 0 (master ACK): go to TX.
    - 1 (master NAK): pulse o_nak and go to WAIT_STOP.
  - WAIT_STOP: SDA released. Leave only on STOP (to IDLE) or START (to ADDR).
- Output handshake: the transfer happens when o_data_valid and i_data_ready are both 1 at a clock edge. o_data_valid is cleared on that edge. o_data_bits holds steady while o_data_valid=1.
- Simultaneous events:
  - A handshake on the same clock as a new byte completing counts as empty, so the new byte is ACKed.
  - STOP on the same clock as a byte completing: the byte is discarded.
- General call (address 0) is not acknowledged.

Optional Feature:
- Macro: I2C_SLAVE_CLOCK_STRETCH_EN.
- Defined:
  - RX: if the output register is still full when a byte completes, hold SCL low (o_scl_oe=1) from the scl_fall after bit 8 until the handshake happens, then ACK the byte. No byte is lost.
  - TX: if i_data_valid=0 at fetch time, hold SCL low until it becomes valid, then send that byte. 8'hFF is never sent.
- Undefined: o_scl_oe is constant 0; the NAK and 8'hFF rules above apply.

Test Plan:
- Master writes 0x84 (addr 0x42, W), 0x5A, 0xC3, then STOP; sink always ready -> ACK on all three bytes; o_data_bits shows 0x5A then 0xC3 with one valid pulse each; o_busy returns to 0 after STOP.
- Master sends 0x86 (addr 0x43) -> SDA never driven low; no output valid; state reaches IDLE after STOP.
- Master sends 0x85 (read), source provides 0x3C then 0xA7, master ACKs then NAKs -> bus carries 0x3C and 0xA7; o_data_ready pulses exactly 2 times; o_nak pulses once.
- Write 0x11, 0x22 with i_data_ready=0 -> 0x11 ACKed, 0x22 NAKed. With the macro defined: SCL is held low until ready is raised, then 0x22 is ACKed.
- Read with i_data_valid=0 -> 0xFF on the bus. With the macro defined: SCL is stretched until valid rises with 0x99, then 0x99 is sent.
- i_rst=0 for one clock in the middle of the address-ACK phase -> o_sda_oe=0 on the next clock; the next START plus 0x84 is ACKed normally.
